// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep sequencer for a combinational gate under test: drives every input vector,
// holds it SETTLE cycles, samples in a one-cycle CHECK and accumulates errors against EXP_TABLE.
module gate_sweep_ctrl #(
  parameter int                  N_IN      = 2,
  parameter int                  SETTLE    = 1,
  parameter logic [2**N_IN-1:0]  EXP_TABLE = 4'b1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] gate_in,
  input  logic            gate_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int              SW       = $clog2(SETTLE + 1);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN-1:0] gate_in_q, gate_in_d;
  logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [N_IN:0]   err_count_q, err_count_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffvec_q, ffvec_d;
  logic            pass_q, pass_d;
  logic            mismatch;

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    gate_in_d    = gate_in_q;
    settle_cnt_d = settle_cnt_q;
    err_count_d  = err_count_q;
    ffv_d        = ffv_q;
    ffvec_d      = ffvec_q;
    pass_d       = pass_q;
    // X or Z from the gate must count as a failure, hence the 4-state compare.
    mismatch     = (gate_out !== EXP_TABLE[vec_q]);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_SETTLE;
          vec_d        = '0;
          gate_in_d    = '0;
          settle_cnt_d = '0;
          err_count_d  = '0;
          ffv_d        = 1'b0;
          ffvec_d      = '0;
          pass_d       = 1'b0;
        end
      end
      S_SETTLE: begin
        settle_cnt_d = settle_cnt_q + SW'(1);
        if (settle_cnt_q == SW'(SETTLE - 1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (mismatch) begin
          err_count_d = err_count_q + (N_IN+1)'(1);
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
          end
        end
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
          pass_d  = (err_count_d == '0);
        end else begin
          vec_d        = vec_q + N_IN'(1);
          gate_in_d    = vec_q + N_IN'(1);
          settle_cnt_d = '0;
          state_d      = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      gate_in_q    <= '0;
      settle_cnt_q <= '0;
      err_count_q  <= '0;
      ffv_q        <= 1'b0;
      ffvec_q      <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      gate_in_q    <= gate_in_d;
      settle_cnt_q <= settle_cnt_d;
      err_count_q  <= err_count_d;
      ffv_q        <= ffv_d;
      ffvec_q      <= ffvec_d;
      pass_q       <= pass_d;
    end
  end

  assign gate_in          = gate_in_q;
  assign busy             = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done             = (state_q == S_DONE);
  assign pass             = pass_q;
  assign err_count        = err_count_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench: default 2-input instance against AND/stuck-0/OR gates, plus a 3-input SETTLE=3 instance.
module tb_gate_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start2;
  logic [1:0] gi;
  logic       go, busy, done, pass, ffv;
  logic [2:0] err;
  logic [1:0] ffvec;
  logic [2:0] gi2;
  logic       go2, busy2, done2, pass2, ffv2;
  logic [3:0] err2;
  logic [2:0] ffvec2;
  int         mode;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  // mode 0: a&b, 1: stuck-at-0, 2: a|b
  assign go  = (mode == 0) ? (&gi) : (mode == 2) ? (|gi) : 1'b0;
  assign go2 = &gi2;

  gate_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .gate_in(gi), .gate_out(go), .busy(busy),
    .done(done), .pass(pass), .err_count(err), .first_fail_valid(ffv), .first_fail_vec(ffvec)
  );

  gate_sweep_ctrl #(.N_IN(3), .SETTLE(3), .EXP_TABLE(8'h80)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .gate_in(gi2), .gate_out(go2), .busy(busy2),
    .done(done2), .pass(pass2), .err_count(err2), .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
  );

  // Pulse start for one cycle; returns 1 time unit after the accepting edge.
  task automatic launch(input bit which);
    @(negedge clk);
    if (which) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
  endtask

  // Count edges until done is seen, bounded so a stuck DUT still reaches the summary.
  task automatic wait_done(input bit which, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(which ? done2 : done) && n < 200);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 0;
    #1;
    total++; if ({gi, busy, done, pass, err, ffv, ffvec} !== 11'd0) begin bad++; $display("FAIL reset_outs got=%b want=0", {gi, busy, done, pass, err, ffv, ffvec}); end
    total++; if ({gi2, busy2, done2, pass2, err2, ffv2, ffvec2} !== 14'd0) begin bad++; $display("FAIL reset_outs2 got=%b want=0", {gi2, busy2, done2, pass2, err2, ffv2, ffvec2}); end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL idle_hold got=%b want=00", {busy, done}); end
  endtask

  task automatic test_and_sweep;
    int n;
    mode = 0;
    launch(0);
    for (int k = 0; k < 8; k++) begin
      total++; if (gi !== 2'(k / 2)) begin bad++; $display("FAIL and_gate_in k=%0d got=%0d want=%0d", k, gi, k / 2); end
      total++; if ({busy, done, pass} !== 3'b100) begin bad++; $display("FAIL and_busy k=%0d got=%b want=100", k, {busy, done, pass}); end
      @(posedge clk); #1;
    end
    total++; if ({busy, done, pass} !== 3'b011) begin bad++; $display("FAIL and_done got=%b want=011", {busy, done, pass}); end
    total++; if ({err, ffv} !== 4'd0) begin bad++; $display("FAIL and_err got=%0d/%b want=0/0", err, ffv); end
    repeat (3) @(posedge clk); #1;
    total++; if ({done, pass, gi} !== 4'b1111) begin bad++; $display("FAIL and_hold got=%b want=1111", {done, pass, gi}); end
    n = 0;
  endtask

  task automatic test_stuck0;
    int n;
    mode = 1;
    launch(0);
    wait_done(0, n);
    total++; if (n !== 8) begin bad++; $display("FAIL stuck_latency got=%0d want=8", n); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL stuck_pass got=%b want=0", pass); end
    total++; if (err !== 3'd1) begin bad++; $display("FAIL stuck_err got=%0d want=1", err); end
    total++; if ({ffv, ffvec} !== 3'b111) begin bad++; $display("FAIL stuck_first got=%b/%0d want=1/3", ffv, ffvec); end
  endtask

  task automatic test_or_restart;
    int n;
    mode = 2;
    launch(0);
    total++; if ({done, err, ffv} !== 5'd0) begin bad++; $display("FAIL or_clear got=%b want=0", {done, err, ffv}); end
    wait_done(0, n);
    total++; if (n !== 8) begin bad++; $display("FAIL or_latency got=%0d want=8", n); end
    total++; if ({pass, err} !== 4'b0010) begin bad++; $display("FAIL or_err got=%b/%0d want=0/2", pass, err); end
    total++; if ({ffv, ffvec} !== 3'b101) begin bad++; $display("FAIL or_first got=%b/%0d want=1/1", ffv, ffvec); end
    mode = 0;
    launch(0);
    total++; if ({done, pass, err, ffv, ffvec} !== 7'd0) begin bad++; $display("FAIL restart_clear got=%b want=0", {done, pass, err, ffv, ffvec}); end
    wait_done(0, n);
    total++; if ({n[3:0], pass, err} !== {4'd8, 1'b1, 3'd0}) begin bad++; $display("FAIL restart_result got=n%0d p%b e%0d want=n8 p1 e0", n, pass, err); end
  endtask

  task automatic test_reset_mid;
    int n;
    mode = 1;
    launch(0);
    repeat (4) @(posedge clk); #1;
    total++; if ({gi, busy} !== 3'b101) begin bad++; $display("FAIL mid_pre got=%0d/%b want=2/1", gi, busy); end
    #2 rst = 1'b1;
    #1;
    total++; if ({gi, busy, done, pass, err, ffv, ffvec} !== 11'd0) begin bad++; $display("FAIL mid_reset got=%b want=0", {gi, busy, done, pass, err, ffv, ffvec}); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL mid_idle got=%b want=00", {busy, done}); end
    mode = 0;
    launch(0);
    total++; if ({gi, busy} !== 3'b001) begin bad++; $display("FAIL mid_relaunch got=%0d/%b want=0/1", gi, busy); end
    wait_done(0, n);
    total++; if ({n[3:0], pass} !== 5'b10001) begin bad++; $display("FAIL mid_result got=n%0d p%b want=n8 p1", n, pass); end
  endtask

  task automatic test_start_held;
    int n;
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    wait_done(0, n);
    total++; if (n !== 8) begin bad++; $display("FAIL held_latency got=%0d want=8", n); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL held_pass got=%b want=1", pass); end
    @(posedge clk); #1;
    total++; if ({busy, done, pass, gi} !== 5'b10000) begin bad++; $display("FAIL held_relaunch got=%b want=10000", {busy, done, pass, gi}); end
    start = 1'b0;
    wait_done(0, n);
    total++; if (n !== 8) begin bad++; $display("FAIL held_second got=%0d want=8", n); end
  endtask

  task automatic test_wide;
    int n;
    launch(1);
    for (int k = 0; k < 32; k++) begin
      total++; if (gi2 !== 3'(k / 4)) begin bad++; $display("FAIL wide_gate_in k=%0d got=%0d want=%0d", k, gi2, k / 4); end
      @(posedge clk); #1;
    end
    n = 32;
    total++; if ({done2, pass2} !== 2'b11) begin bad++; $display("FAIL wide_done after=%0d got=%b want=11", n, {done2, pass2}); end
    total++; if ({err2, ffv2} !== 5'd0) begin bad++; $display("FAIL wide_err got=%0d/%b want=0/0", err2, ffv2); end
    launch(1);
    wait_done(1, n);
    total++; if (n !== 32) begin bad++; $display("FAIL wide_latency got=%0d want=32", n); end
  endtask

  initial begin
    test_reset();
    test_and_sweep();
    test_stuck0();
    test_or_restart();
    test_reset_mid();
    test_start_held();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
